// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one shared full-adder cell is stepped LSB first,
// with a valid/ready handshake on the operand side and another on the result side.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;

  // Shared full-adder cell: two half adders plus an OR on their carries.
  logic fa_a, fa_b, fa_cin;
  logic ha1_s, ha1_c, ha2_s, ha2_c;
  logic fa_s, fa_cout;

  always_comb begin
    fa_a    = a_q[bit_idx_q];
    fa_b    = b_q[bit_idx_q];
    fa_cin  = carry_q;
    ha1_s   = fa_a ^ fa_b;
    ha1_c   = fa_a & fa_b;
    ha2_s   = ha1_s ^ fa_cin;
    ha2_c   = ha1_s & fa_cin;
    fa_s    = ha2_s;
    fa_cout = ha1_c | ha2_c;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    bit_idx_d = bit_idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with op_sub.
          a_d       = op_a;
          b_d       = op_sub ? ~op_b : op_b;
          carry_d   = op_sub;
          bit_idx_d = '0;
          sum_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        sum_d[bit_idx_q] = fa_s;
        carry_d          = fa_cout;
        if (bit_idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry_out = carry_q;

endmodule
